// File: rtl/sonata_pkg.sv
// sonata_pkg: shared word width and default filler byte for the spi target
package sonata_pkg;
   localparam int unsigned word_w = 8;
   localparam logic [word_w-1:0] filler_byte_default = 8'hFF;
endpackage

// File: rtl/spi_target_if.sv
// spi_target_if: host pins plus rx/tx byte streams of the spi target
interface spi_target_if;
   import sonata_pkg::*;
   logic              sclk_i;
   logic              cs_ni;
   logic              copi_i;
   logic              cipo_o;
   logic              cipo_en_o;
   logic [word_w-1:0] rx_data_o;
   logic              rx_valid_o;
   logic              rx_ready_i;
   logic [word_w-1:0] tx_data_i;
   logic              tx_valid_i;
   logic              tx_ready_o;
   logic              rx_overflow_o;
   logic              tx_underflow_o;
   logic              frame_end_o;
   modport slave (
      input  sclk_i, cs_ni, copi_i, rx_ready_i, tx_data_i, tx_valid_i,
      output cipo_o, cipo_en_o, rx_data_o, rx_valid_o, tx_ready_o,
             rx_overflow_o, tx_underflow_o, frame_end_o
   );
   modport master (
      output sclk_i, cs_ni, copi_i, rx_ready_i, tx_data_i, tx_valid_i,
      input  cipo_o, cipo_en_o, rx_data_o, rx_valid_o, tx_ready_o,
             rx_overflow_o, tx_underflow_o, frame_end_o
   );
endinterface

// File: rtl/spi_target_sync.sv
// spi_target_sync: flop chain bringing an asynchronous pin into clk_i
module spi_target_sync #(
   parameter int unsigned Stages = 2,
   parameter logic        RstVal = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);
   logic [Stages-1:0] sync_q, sync_d;
   // shift the pin level one stage per clock
   always_comb sync_d = {sync_q[Stages-2:0], d_i};
   // chain resets to the idle level of the pin
   always_ff @(posedge clk_i) sync_q <= rst_i ? {Stages{RstVal}} : sync_d;
   assign q_o = sync_q[Stages-1];
endmodule

// File: rtl/spi_target.sv
// spi_target: mode-0 spi responder with rx/tx byte streams, oversampled by clk_i
module spi_target import sonata_pkg::*; #(
   parameter int unsigned       SyncStages = 2,
   parameter logic [word_w-1:0] FillerByte = filler_byte_default
) (
   input logic          clk_i,
   input logic          rst_i,
   spi_target_if.slave  bus
);
   typedef enum logic {IDLE, ACTIVE} state_e;
   state_e            state_q, state_d;
   logic              sclk_s, cs_n_s, copi_s;
   logic              sclk_q, sclk_d, cs_n_q, cs_n_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [word_w-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d, rx_ovf_q, rx_ovf_d, frame_end_q, frame_end_d;
   logic              sclk_rise, sclk_fall, cs_fall, cs_rise, active, load, deliver, wr;
   spi_target_sync #(.Stages(SyncStages), .RstVal(1'b0)) u_sync_sclk (.clk_i, .rst_i, .d_i(bus.sclk_i), .q_o(sclk_s));
   spi_target_sync #(.Stages(SyncStages), .RstVal(1'b1)) u_sync_cs   (.clk_i, .rst_i, .d_i(bus.cs_ni),  .q_o(cs_n_s));
   spi_target_sync #(.Stages(SyncStages), .RstVal(1'b0)) u_sync_copi (.clk_i, .rst_i, .d_i(bus.copi_i), .q_o(copi_s));
   // edge detection, tx reload and byte delivery decisions
   always_comb begin
      sclk_rise = sclk_s & ~sclk_q;
      sclk_fall = ~sclk_s & sclk_q;
      cs_fall   = ~cs_n_s & cs_n_q;
      cs_rise   = cs_n_s & ~cs_n_q;
      active    = (state_q == ACTIVE) & ~cs_rise;
      load      = ~rst_i & (((state_q == IDLE) & cs_fall) | (active & sclk_fall & (bit_cnt_q == 3'd0)));
      deliver   = active & sclk_rise & (bit_cnt_q == 3'd7);
      wr        = deliver & (~rx_valid_q | bus.rx_ready_i);
   end
   // next-state for the frame tracker, shifters and rx holding register
   always_comb begin
      sclk_d      = sclk_s;
      cs_n_d      = cs_n_s;
      state_d     = (state_q == IDLE) ? (cs_fall ? ACTIVE : IDLE) : (cs_rise ? IDLE : ACTIVE);
      bit_cnt_d   = active ? (sclk_rise ? bit_cnt_q + 3'd1 : bit_cnt_q) : 3'd0;
      rx_shift_d  = (active & sclk_rise) ? {rx_shift_q[word_w-2:0], copi_s} : rx_shift_q;
      tx_shift_d  = load ? (bus.tx_valid_i ? bus.tx_data_i : FillerByte)
                  : (active & sclk_fall) ? {tx_shift_q[word_w-2:0], 1'b0} : tx_shift_q;
      rx_data_d   = wr ? {rx_shift_q[word_w-2:0], copi_s} : rx_data_q;
      rx_valid_d  = wr | (rx_valid_q & ~bus.rx_ready_i);
      rx_ovf_d    = deliver & ~wr;
      frame_end_d = (state_q == ACTIVE) & cs_rise;
   end
   // state registers; reset abandons any frame in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         sclk_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         rx_ovf_q    <= 1'b0;
         frame_end_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         rx_ovf_q    <= rx_ovf_d;
         frame_end_q <= frame_end_d;
      end
   end
   assign bus.cipo_o         = (state_q == ACTIVE) & tx_shift_q[word_w-1];
   assign bus.cipo_en_o      = (state_q == ACTIVE);
   assign bus.rx_data_o      = rx_data_q;
   assign bus.rx_valid_o     = rx_valid_q;
   assign bus.tx_ready_o     = load & bus.tx_valid_i;
   assign bus.tx_underflow_o = load & ~bus.tx_valid_i;
   assign bus.rx_overflow_o  = rx_ovf_q;
   assign bus.frame_end_o    = frame_end_q;
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed frames from a behavioural mode-0 host against spi_target
module tb_spi_target;
   typedef logic [7:0] bytes_t [4];
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   spi_target_if spi_if();
   spi_target #(.SyncStages(2), .FillerByte(8'hFF)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(spi_if));
   always #5 clk_i = ~clk_i;
   int n_chk = 0, n_fail = 0;
   int n_txr, n_unf, n_ovf, n_fe, n_rxv;
   bit pend = 1'b0;
   logic [7:0] tx_q[$];
   logic [7:0] rx_got[$];
   bytes_t mi;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic clr();
      n_txr = 0; n_unf = 0; n_ovf = 0; n_fe = 0; n_rxv = 0;
      rx_got.delete();
   endtask
   // tx source, rx sink and pulse counters, all sampled mid-cycle
   always @(negedge clk_i) begin
      if (pend) begin
         void'(tx_q.pop_front());
         pend = 1'b0;
      end
      if (spi_if.tx_ready_o) begin n_txr++; pend = 1'b1; end
      if (spi_if.tx_underflow_o) n_unf++;
      if (spi_if.rx_overflow_o) n_ovf++;
      if (spi_if.frame_end_o) n_fe++;
      if (spi_if.rx_valid_o) n_rxv++;
      if (spi_if.rx_valid_o && spi_if.rx_ready_i) rx_got.push_back(spi_if.rx_data_o);
      spi_if.tx_valid_i = tx_q.size() != 0;
      spi_if.tx_data_i  = tx_q.size() != 0 ? tx_q[0] : 8'h00;
   end
   // mode-0 host: 4-cycle SCLK phases; optionally leaves the frame open with SCLK high
   task automatic host_frame(input bytes_t mo, input int nbits, input bit close, output bytes_t rd);
      for (int b = 0; b < 4; b++) rd[b] = 8'h00;
      spi_if.cs_ni = 1'b0;
      repeat (6) @(negedge clk_i);
      check("cipo_en_active", spi_if.cipo_en_o, 1);
      for (int i = 0; i < nbits; i++) begin
         spi_if.copi_i = mo[i/8][7-i%8];
         repeat (4) @(negedge clk_i);
         rd[i/8][7-i%8] = spi_if.cipo_o;
         spi_if.sclk_i = 1'b1;
         repeat (4) @(negedge clk_i);
         if (i != nbits - 1) spi_if.sclk_i = 1'b0;
      end
      if (close) begin
         spi_if.cs_ni = 1'b1;
         repeat (4) @(negedge clk_i);
         spi_if.sclk_i = 1'b0;
         repeat (8) @(negedge clk_i);
      end
   endtask
   initial begin
      spi_if.sclk_i = 1'b0; spi_if.cs_ni = 1'b1; spi_if.copi_i = 1'b0;
      spi_if.rx_ready_i = 1'b1; spi_if.tx_valid_i = 1'b0; spi_if.tx_data_i = 8'h00;
      tx_q.push_back(8'h3C);
      repeat (4) @(negedge clk_i);
      check("rst_cipo", spi_if.cipo_o, 0);
      check("rst_cipo_en", spi_if.cipo_en_o, 0);
      check("rst_rx_valid", spi_if.rx_valid_o, 0);
      check("rst_rx_data", spi_if.rx_data_o, 0);
      check("rst_tx_ready", spi_if.tx_ready_o, 0);
      check("rst_frame_end", spi_if.frame_end_o, 0);
      rst_i = 1'b0;
      repeat (4) @(negedge clk_i);
      clr();
      host_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 8, 1'b1, mi);
      check("single_miso", mi[0], 8'h3C);
      check("single_rx_cnt", rx_got.size(), 1);
      check("single_rx", rx_got.size() > 0 ? rx_got[0] : 8'h00, 8'hA5);
      check("single_rxv_cycles", n_rxv, 1);
      check("single_tx_ready", n_txr, 1);
      check("single_underflow", n_unf, 0);
      check("single_frame_end", n_fe, 1);
      check("idle_cipo_en", spi_if.cipo_en_o, 0);
      clr();
      host_frame('{8'h00, 8'h00, 8'h00, 8'h00}, 16, 1'b1, mi);
      check("unf_miso0", mi[0], 8'hFF);
      check("unf_miso1", mi[1], 8'hFF);
      check("unf_pulses", n_unf, 2);
      check("unf_tx_ready", n_txr, 0);
      clr();
      spi_if.rx_ready_i = 1'b0;
      host_frame('{8'h11, 8'h22, 8'h00, 8'h00}, 16, 1'b1, mi);
      check("ovf_rx_valid", spi_if.rx_valid_o, 1);
      check("ovf_rx_data", spi_if.rx_data_o, 8'h11);
      check("ovf_pulses", n_ovf, 1);
      spi_if.rx_ready_i = 1'b1;
      repeat (2) @(negedge clk_i);
      check("ovf_drain_valid", spi_if.rx_valid_o, 0);
      check("ovf_drain_data", rx_got.size() > 0 ? rx_got[0] : 8'h00, 8'h11);
      clr();
      host_frame('{8'hF0, 8'h00, 8'h00, 8'h00}, 5, 1'b1, mi);
      host_frame('{8'h81, 8'h00, 8'h00, 8'h00}, 8, 1'b1, mi);
      check("abort_rx_cnt", rx_got.size(), 1);
      check("abort_rx", rx_got.size() > 0 ? rx_got[0] : 8'h00, 8'h81);
      check("abort_frame_end", n_fe, 2);
      clr();
      for (int b = 1; b <= 4; b++) tx_q.push_back(8'(b));
      repeat (2) @(negedge clk_i);
      host_frame('{8'h01, 8'h02, 8'h03, 8'h04}, 32, 1'b1, mi);
      for (int b = 0; b < 4; b++) begin
         check("b2b_miso", mi[b], 8'(b + 1));
         check("b2b_rx", rx_got.size() > b ? rx_got[b] : 8'h00, 8'(b + 1));
      end
      check("b2b_rx_cnt", rx_got.size(), 4);
      check("b2b_overflow", n_ovf, 0);
      check("b2b_underflow", n_unf, 0);
      check("b2b_tx_ready", n_txr, 4);
      clr();
      host_frame('{8'hE7, 8'h00, 8'h00, 8'h00}, 3, 1'b0, mi);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("mid_rst_cipo", spi_if.cipo_o, 0);
      check("mid_rst_cipo_en", spi_if.cipo_en_o, 0);
      check("mid_rst_rx_data", spi_if.rx_data_o, 0);
      check("mid_rst_rx_valid", spi_if.rx_valid_o, 0);
      check("mid_rst_pulses", {spi_if.tx_ready_o, spi_if.tx_underflow_o, spi_if.rx_overflow_o, spi_if.frame_end_o}, 0);
      spi_if.cs_ni = 1'b1;
      spi_if.sclk_i = 1'b0;
      repeat (4) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (4) @(negedge clk_i);
      clr();
      tx_q.push_back(8'h5A);
      repeat (2) @(negedge clk_i);
      host_frame('{8'hC3, 8'h00, 8'h00, 8'h00}, 8, 1'b1, mi);
      check("post_rst_rx_cnt", rx_got.size(), 1);
      check("post_rst_rx", rx_got.size() > 0 ? rx_got[0] : 8'h00, 8'hC3);
      check("post_rst_miso", mi[0], 8'h5A);
      check("post_rst_frame_end", n_fe, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
